// File: rtl/pixel_scan_generator_if.sv
// rtl/pixel_scan_generator_if.sv - pixel coordinate stream and completion return between scan generator and ray pipeline
interface pixel_scan_generator_if;
    logic [31:0] screen_x;
    logic [31:0] screen_y;
    logic        valid_out;
    logic        ret_valid;

    modport master (
        output screen_x,
        output screen_y,
        output valid_out,
        input  ret_valid
    );

    modport slave (
        input  screen_x,
        input  screen_y,
        input  valid_out,
        output ret_valid
    );
endinterface

// File: rtl/pixel_scan_generator.sv
// rtl/pixel_scan_generator.sv - raster-order pixel issue with credit throttling; PIXEL_SCAN_CONTINUOUS_EN selects free-running frames
module pixel_scan_generator #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int MAX_INFLIGHT  = 64,
    parameter int FRAC_BITS     = 21
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              stall,
    pixel_scan_generator_if.master            pix,
    output logic                              busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              frame_done,
    output logic                              err_underflow
);

    localparam int X_W   = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int Y_W   = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [X_W-1:0]   X_LAST    = X_W'(SCREEN_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(SCREEN_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic [X_W-1:0]   x_q,          x_d;
    logic [Y_W-1:0]   y_q,          y_d;
    logic [31:0]      screen_x_q,   screen_x_d;
    logic [31:0]      screen_y_q,   screen_y_d;
    logic             valid_q,      valid_d;
    logic             busy_q,       busy_d;
    logic [CNT_W-1:0] inflight_q,   inflight_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q,        err_d;

    logic issue;
    logic ret_ok;
    logic last_x;
    logic last_y;

    // Issue is judged on the registered credit count, so a return arriving
    // while full only frees the slot for the following cycle.
    always_comb begin
        issue  = (state_q == SCAN) && !stall && (inflight_q < CNT_LIMIT);
        ret_ok = pix.ret_valid && (inflight_q != '0);
        last_x = (x_q == X_LAST);
        last_y = (y_q == Y_LAST);
    end

    // Next-state, coordinate and credit computation.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        screen_x_d   = screen_x_q;
        screen_y_d   = screen_y_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        inflight_d   = inflight_q;
        err_d        = err_q;

        // Simultaneous issue and return cancel out.
        if (issue && !ret_ok) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && ret_ok) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        // A return with nothing outstanding is a downstream protocol error.
        if (pix.ret_valid && (inflight_q == '0) && !issue) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end

            SCAN: begin
                if (issue) begin
                    valid_d    = 1'b1;
                    screen_x_d = {{(32-X_W){1'b0}}, x_q} << FRAC_BITS;
                    screen_y_d = {{(32-Y_W){1'b0}}, y_q} << FRAC_BITS;
                    if (last_x) begin
                        x_d = '0;
                        y_d = last_y ? '0 : (y_q + Y_W'(1));
                        if (last_y) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
            end

            DRAIN: begin
                // The last completion may land on this very edge.
                if (inflight_d == '0) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end

            DONE: begin
`ifdef PIXEL_SCAN_CONTINUOUS_EN
                state_d = SCAN;
                x_d     = '0;
                y_d     = '0;
`else
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SCAN) || (state_d == DRAIN);
    end

    // State and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            screen_x_q   <= '0;
            screen_y_q   <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            inflight_q   <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            screen_x_q   <= screen_x_d;
            screen_y_q   <= screen_y_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            inflight_q   <= inflight_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign pix.screen_x   = screen_x_q;
    assign pix.screen_y   = screen_y_q;
    assign pix.valid_out  = valid_q;
    assign busy           = busy_q;
    assign inflight       = inflight_q;
    assign frame_done     = frame_done_q;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_pixel_scan_generator.sv
// tb/tb_pixel_scan_generator.sv - self-checking bench for pixel_scan_generator
module tb_pixel_scan_generator;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, stall_a, busy_a, frame_done_a, err_a;
    logic start_b, stall_b, busy_b, frame_done_b, err_b;
    logic [4:0] inflight_a;
    logic [1:0] inflight_b;

    pixel_scan_generator_if a_if ();
    pixel_scan_generator_if b_if ();

    pixel_scan_generator #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .MAX_INFLIGHT(16), .FRAC_BITS(21)) dut_a (
        .clk(clk), .rst(rst_n), .start(start_a), .stall(stall_a), .pix(a_if),
        .busy(busy_a), .inflight(inflight_a), .frame_done(frame_done_a), .err_underflow(err_a)
    );

    pixel_scan_generator #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .MAX_INFLIGHT(3), .FRAC_BITS(21)) dut_b (
        .clk(clk), .rst(rst_n), .start(start_b), .stall(stall_b), .pix(b_if),
        .busy(busy_b), .inflight(inflight_b), .frame_done(frame_done_b), .err_underflow(err_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [4:0]  pipe_a;
    int a_last_beat_cyc = 0;
    int a_done_cnt = 0;
    int a_done_cyc = 0;
    int a_done1_cyc = 0;
    int a_zero_cnt = 0;
    int a_zero2_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pix(input int x, input int y);
        logic [31:0] fx;
        logic [31:0] fy;
        fx = 32'(x) << 21;
        fy = 32'(y) << 21;
        return {fx, fy};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done_a(input int target, input string tag);
        int n = 0;
        while (a_done_cnt < target && n < 100) begin
            step();
            n++;
        end
        chk(tag, 64'(a_done_cnt >= target), 64'd1);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard for both DUTs, plus the delayed completion echo for dut_a.
    always @(negedge clk) begin
        if (!rst_n) begin
            pipe_a         = '0;
            a_if.ret_valid = 1'b0;
        end else begin
            a_if.ret_valid = pipe_a[4];
            pipe_a         = {pipe_a[3:0], a_if.valid_out};
            if (a_if.valid_out) begin
                a_last_beat_cyc = cyc;
                if ({a_if.screen_x, a_if.screen_y} == 64'd0) begin
                    a_zero_cnt++;
                    if (a_zero_cnt == 2) a_zero2_cyc = cyc;
                end
                chk("a_beat_expected", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) chk("a_pixel", {a_if.screen_x, a_if.screen_y}, qa.pop_front());
            end
            if (frame_done_a) begin
                a_done_cnt++;
                a_done_cyc = cyc;
                if (a_done_cnt == 1) a_done1_cyc = cyc;
            end
            if (b_if.valid_out) begin
                chk("b_beat_expected", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0) chk("b_pixel", {b_if.screen_x, b_if.screen_y}, qb.pop_front());
            end
        end
    end

    initial begin
        int done_before;
        rst_n = 1'b0;
        start_a = 1'b0; stall_a = 1'b0;
        start_b = 1'b0; stall_b = 1'b0;
        b_if.ret_valid = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_valid", 64'(a_if.valid_out), 64'd0);
        chk("rst_sx", 64'(a_if.screen_x), 64'd0);
        chk("rst_sy", 64'(a_if.screen_y), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_inflight", 64'(inflight_a), 64'd0);
        chk("rst_done", 64'(frame_done_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        rst_n = 1'b1;
        step();

        // Frame 1 on dut_a: latency, raster order, completion timing
        for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) qa.push_back(pix(x, y));
`ifdef PIXEL_SCAN_CONTINUOUS_EN
        for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) qa.push_back(pix(x, y));
`endif
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("a_latency_k", 64'(a_if.valid_out), 64'd0);
        chk("a_busy_scan", 64'(busy_a), 64'd1);
        step();
        chk("a_latency_k1", 64'(a_if.valid_out), 64'd1);
        step();
        chk("a_x1_fixed", 64'(a_if.screen_x), 64'h0020_0000);

`ifdef PIXEL_SCAN_CONTINUOUS_EN
        wait_done_a(2, "c_two_frames_done");
        #2 rst_n = 1'b0;
        #1;
        chk("c_gap_after_done", 64'(a_zero2_cyc - a_done1_cyc), 64'd2);
        chk("c_queue_empty", 64'(qa.size()), 64'd0);
        chk("c_err", 64'(err_a), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
`else
        wait_done_a(1, "a_frame1_done");
        repeat (3) step();
        chk("a_done_once", 64'(a_done_cnt), 64'd1);
        chk("a_done_delay", 64'(a_done_cyc - a_last_beat_cyc), 64'd6);
        chk("a_busy_after", 64'(busy_a), 64'd0);
        chk("a_queue_empty1", 64'(qa.size()), 64'd0);
        chk("a_inflight_zero", 64'(inflight_a), 64'd0);

        // Frame 2 on dut_a: stall for 4 cycles at x=2
        for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) qa.push_back(pix(x, y));
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        stall_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("a_stall_quiet", 64'(a_if.valid_out), 64'd0);
        end
        stall_a = 1'b0;
        step();
        chk("a_resume_valid", 64'(a_if.valid_out), 64'd1);
        chk("a_resume_x2", 64'(a_if.screen_x), 64'h0040_0000);
        wait_done_a(2, "a_frame2_done");
        repeat (3) step();
        chk("a_queue_empty2", 64'(qa.size()), 64'd0);

        // dut_b: credit limit of 3 with no returns
        qb.push_back(pix(0, 0)); qb.push_back(pix(1, 0)); qb.push_back(pix(2, 0));
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        repeat (8) step();
        chk("b_inflight_full", 64'(inflight_b), 64'd3);
        chk("b_held_idle_out", 64'(b_if.valid_out), 64'd0);
        chk("b_queue_3beats", 64'(qb.size()), 64'd0);

        // One return frees exactly one beat, not on the same edge
        qb.push_back(pix(3, 0));
        b_if.ret_valid = 1'b1;
        step();
        b_if.ret_valid = 1'b0;
        chk("b_no_issue_at_max", 64'(b_if.valid_out), 64'd0);
        chk("b_inflight_after_ret", 64'(inflight_b), 64'd2);
        step();
        chk("b_one_more_beat", 64'(b_if.valid_out), 64'd1);
        chk("b_inflight_refull", 64'(inflight_b), 64'd3);
        step();
        chk("b_quiet_again", 64'(b_if.valid_out), 64'd0);

        // Issue and return on the same edge at inflight=2
        qb.push_back(pix(0, 1)); qb.push_back(pix(1, 1));
        b_if.ret_valid = 1'b1;
        step();
        chk("b_inflight_2", 64'(inflight_b), 64'd2);
        step();
        b_if.ret_valid = 1'b0;
        chk("b_same_edge_valid", 64'(b_if.valid_out), 64'd1);
        chk("b_same_edge_inflight", 64'(inflight_b), 64'd2);
        step();
        chk("b_inflight_3_end", 64'(inflight_b), 64'd3);
        step();
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        chk("b_err_clear", 64'(err_b), 64'd0);

        // Frame 3 on dut_a: reset at pixel (1,1)
        for (int x = 0; x < 4; x++) qa.push_back(pix(x, 0));
        qa.push_back(pix(0, 1)); qa.push_back(pix(1, 1));
        done_before = a_done_cnt;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (6) step();
        chk("a_at_pixel_11", {a_if.screen_x, a_if.screen_y}, pix(1, 1));
        #2 rst_n = 1'b0;
        #1;
        chk("a_abort_valid", 64'(a_if.valid_out), 64'd0);
        chk("a_abort_sx", 64'(a_if.screen_x), 64'd0);
        chk("a_abort_sy", 64'(a_if.screen_y), 64'd0);
        chk("a_abort_busy", 64'(busy_a), 64'd0);
        chk("a_abort_inflight", 64'(inflight_a), 64'd0);
        chk("a_abort_done", 64'(frame_done_a), 64'd0);
        chk("b_abort_inflight", 64'(inflight_b), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("a_no_done_on_abort", 64'(a_done_cnt), 64'(done_before));
        chk("a_queue_empty3", 64'(qa.size()), 64'd0);

        // Underflow on dut_b in IDLE is sticky
        b_if.ret_valid = 1'b1;
        step();
        b_if.ret_valid = 1'b0;
        chk("b_underflow_set", 64'(err_b), 64'd1);
        chk("b_underflow_inflight", 64'(inflight_b), 64'd0);
        repeat (3) step();
        chk("b_underflow_sticky", 64'(err_b), 64'd1);

        // Frame 4 on dut_a: restart from (0,0) after abort
        for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) qa.push_back(pix(x, y));
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done_a(done_before + 1, "a_frame4_done");
        repeat (3) step();
        chk("a_queue_empty4", 64'(qa.size()), 64'd0);
        chk("a_err_never", 64'(err_a), 64'd0);
        chk("a_busy_final", 64'(busy_a), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
